// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable data width, parity and stop bits, fed by a
// small FIFO so queued words go out back-to-back without idle gaps.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          uart_tx,
  output logic                          ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STOP_BITS * DELAY_FRAMES) + 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_BITS * DELAY_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ZERO_COUNT = (PTR_W + 1)'(0);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Odd parity is the inverted XOR so the total count of ones comes out odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    return (PARITY == 1) ? ~(^word) : (^word);
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W:0]       count_r;
  logic [PTR_W:0]       count_next_s;
  logic                 ready_r;
  logic                 push_s;
  logic                 pop_s;
  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]     idx_r;
  logic [DATA_BITS-1:0] word_r;

  assign push_s     = start && ready_r;
  assign ready      = ready_r;
  assign fifo_count = count_r;

  // Pop decision: only from IDLE or on the final stop-bit cycle.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: pop_s = (count_r != ZERO_COUNT);
      ST_STOP: pop_s = (cnt_r == STOP_LAST) && (count_r != ZERO_COUNT);
      default: pop_s = 1'b0;
    endcase
  end

  // Occupancy after this edge.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + (PTR_W + 1)'(1);
      2'b01:   count_next_s = count_r - (PTR_W + 1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // FIFO pointers, occupancy and registered ready flag.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= ZERO_COUNT;
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != FULL_COUNT);
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      word_r  <= {DATA_BITS{1'b0}};
      uart_tx <= 1'b1;
      busy    <= 1'b0;
    end else begin
      busy <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            word_r  <= mem_r[rd_ptr_r];
            uart_tx <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_START;
          end else begin
            uart_tx <= 1'b1;
            busy    <= (count_next_s != ZERO_COUNT);
          end
        end
        ST_START: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            uart_tx <= word_r[0];
            state_r <= ST_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
              if (PARITY != 0) begin
                uart_tx <= parity_bit(word_r);
                state_r <= ST_PARITY;
              end else begin
                uart_tx <= 1'b1;
                state_r <= ST_STOP;
              end
            end else begin
              idx_r   <= idx_r + IDX_W'(1);
              uart_tx <= word_r[idx_r + IDX_W'(1)];
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            uart_tx <= 1'b1;
            state_r <= ST_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_r == STOP_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
            // Chain straight into the next start bit when data is waiting.
            if (pop_s) begin
              word_r  <= mem_r[rd_ptr_r];
              uart_tx <= 1'b0;
              state_r <= ST_START;
            end else begin
              uart_tx <= 1'b1;
              busy    <= (count_next_s != ZERO_COUNT);
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r   <= {CNT_W{1'b0}};
          uart_tx <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations checked every cycle against a
// frame-level reference model (FIFO of words plus position within the frame).
module tb_uart_tx_fifo;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       start_v [3];
  logic [7:0] data_v  [3];
  logic       tx_v    [3];
  logic       rdy_v   [3];
  logic       bsy_v   [3];
  logic [2:0] cnt_v   [3];

  always #5 sys_clk = ~sys_clk;

  uart_tx_fifo #(.DELAY_FRAMES(D), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_8n1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_v[0]), .data(data_v[0]),
    .uart_tx(tx_v[0]), .ready(rdy_v[0]), .busy(bsy_v[0]), .fifo_count(cnt_v[0]));
  uart_tx_fifo #(.DELAY_FRAMES(D), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_7e2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_v[1]), .data(data_v[1][6:0]),
    .uart_tx(tx_v[1]), .ready(rdy_v[1]), .busy(bsy_v[1]), .fifo_count(cnt_v[1]));
  uart_tx_fifo #(.DELAY_FRAMES(D), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_7o2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_v[2]), .data(data_v[2][6:0]),
    .uart_tx(tx_v[2]), .ready(rdy_v[2]), .busy(bsy_v[2]), .fifo_count(cnt_v[2]));

  int nb_c  [3] = '{8, 7, 7};
  int par_c [3] = '{0, 2, 1};
  int sb_c  [3] = '{1, 2, 2};

  // Reference model: queued words, and the cycle position inside the current frame (-1 = idle).
  logic [7:0] fmem [3][DEPTH];
  int         fhead [3];
  int         fsize [3];
  int         pos   [3];
  logic [7:0] cur   [3];
  logic       exp_tx   [3];
  logic       exp_busy [3];

  int checks = 0;
  int errors = 0;

  function automatic int flen(input int d);
    return D * (1 + nb_c[d] + ((par_c[d] != 0) ? 1 : 0) + sb_c[d]);
  endfunction

  // Line level for bit slot 'slot' of a frame carrying word b.
  function automatic logic exp_bit(input int d, input logic [7:0] b, input int slot);
    logic [7:0] m;
    m = b & 8'((9'd1 << nb_c[d]) - 9'd1);
    if (slot == 0) return 1'b0;
    if (slot <= nb_c[d]) return m[slot-1];
    if (slot == nb_c[d] + 1 && par_c[d] != 0) return (par_c[d] == 2) ? (^m) : ~(^m);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, d, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      fhead[d]    = 0;
      fsize[d]    = 0;
      pos[d]      = -1;
      cur[d]      = 8'h00;
      exp_tx[d]   = 1'b1;
      exp_busy[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 3; d++) begin
      logic acc;
      acc = start_v[d] && (fsize[d] < DEPTH);
      if (pos[d] >= 0) begin
        pos[d]++;
        if (pos[d] == flen(d)) pos[d] = -1;
      end
      if (pos[d] < 0 && fsize[d] > 0) begin
        cur[d]   = fmem[d][fhead[d]];
        fhead[d] = (fhead[d] + 1) % DEPTH;
        fsize[d]--;
        pos[d]   = 0;
      end
      if (acc) begin
        fmem[d][(fhead[d] + fsize[d]) % DEPTH] = data_v[d];
        fsize[d]++;
      end
      exp_tx[d]   = (pos[d] >= 0) ? exp_bit(d, cur[d], pos[d] / D) : 1'b1;
      exp_busy[d] = (pos[d] >= 0) || (fsize[d] > 0);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 3; d++) begin
      chk("uart_tx", d, 8'(tx_v[d]), 8'(exp_tx[d]));
      chk("ready", d, 8'(rdy_v[d]), 8'(fsize[d] < DEPTH));
      chk("busy", d, 8'(bsy_v[d]), 8'(exp_busy[d]));
      chk("fifo_count", d, 8'(cnt_v[d]), 8'(fsize[d]));
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic drive(input int d, input logic [7:0] b);
    start_v[d] = 1'b1;
    data_v[d]  = b;
  endtask

  task automatic release_all();
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
  endtask

  logic [9:0] a5_line = 10'b1_1010_0101_0;
  int         fill_exp [6] = '{1, 1, 2, 3, 4, 4};
  logic [7:0] fill_rdy [6] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0;
      data_v[d]  = 8'h00;
    end
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    repeat (20) step();

    // 8N1 single word, directed mid-bit samples and busy timing
    drive(0, 8'hA5);
    step();
    release_all();
    for (int i = 0; i < 40; i++) begin
      step();
      if (i % 4 == 2) chk("a5_midbit", 0, 8'(tx_v[0]), 8'(a5_line[i / 4]));
    end
    chk("busy_last_stop", 0, 8'(bsy_v[0]), 8'd1);
    step();
    chk("busy_after_frame", 0, 8'(bsy_v[0]), 8'd0);

    // 7-bit even/odd parity, two stop bits
    drive(1, 8'h55);
    drive(2, 8'h55);
    step();
    release_all();
    for (int i = 0; i < 44; i++) begin
      step();
      if (i == 4 * 8 + 2) begin
        chk("parity_even", 1, 8'(tx_v[1]), 8'd0);
        chk("parity_odd", 2, 8'(tx_v[2]), 8'd1);
      end
    end
    repeat (4) step();

    // random single frames on every configuration
    for (int n = 0; n < 3; n++) begin
      for (int d = 0; d < 3; d++) drive(d, 8'($urandom));
      step();
      release_all();
      repeat (50) step();
    end

    // fill the FIFO, overflow push dropped, frames back-to-back
    for (int i = 0; i < 6; i++) begin
      drive(0, 8'(i + 1));
      step();
      chk("fill_count", 0, 8'(cnt_v[0]), 8'(fill_exp[i]));
      chk("fill_ready", 0, 8'(rdy_v[0]), fill_rdy[i]);
    end
    release_all();
    repeat (5 * 40 + 10) step();

    // push on the same edge as the end-of-stop pop with two words queued
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'($urandom));
      step();
    end
    release_all();
    for (int i = 0; i < 100 && !(pos[0] == flen(0) - 1 && fsize[0] == 2); i++) step();
    chk("sync_stop_end", 0, 8'(pos[0] == flen(0) - 1 && fsize[0] == 2), 8'd1);
    drive(0, 8'($urandom));
    step();
    release_all();
    chk("simul_count", 0, 8'(cnt_v[0]), 8'd2);
    repeat (3 * 40 + 10) step();

    // reset in the middle of data bit 3 of a 3-word burst
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'($urandom));
      step();
    end
    release_all();
    for (int i = 0; i < 100 && pos[0] != 4 * D + 1; i++) step();
    chk("sync_bit3", 0, 8'(pos[0] == 4 * D + 1), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 0, 8'(tx_v[0]), 8'd1);
    chk("rst_async_count", 0, 8'(cnt_v[0]), 8'd0);
    chk("rst_async_ready", 0, 8'(rdy_v[0]), 8'd1);
    chk("rst_async_busy", 0, 8'(bsy_v[0]), 8'd0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    repeat (60) step();

    // random traffic including overflow attempts
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 3; d++) begin
        start_v[d] = ($urandom_range(0, 3) == 0);
        data_v[d]  = 8'($urandom);
      end
      step();
    end
    release_all();
    repeat (250) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter, successor to the fixed 8N1 TX path.
- Configurable data width, parity and stop bits, plus a small input FIFO so the CPU/MMIO side can queue bytes without waiting per frame.
- Sits between the memory-mapped UART register block and the board TX pin.
- Frames are sent back-to-back with no idle gap while the FIFO holds data.

Parameters:
- DELAY_FRAMES, 234: sys_clk cycles per bit (clock Hz / baud). Must be >= 2.
- DATA_BITS, 8: data bits per frame, legal 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 4: entries; power of two, legal 2..16.

Ports:
- sys_clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  push request; accepted only when start=1 and ready=1 at the same posedge.
- data  input  DATA_BITS  byte to queue, sampled on the accepting edge.
- uart_tx  output  1  serial line, idles high.
- ready  output  1  1 when FIFO not full.
- busy  output  1  1 when the FSM is not IDLE or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued entries.

Behaviour:
- Reset (async assert, sync release):
  - uart_tx=1, ready=1, busy=0, fifo_count=0.
  - FSM=IDLE; FIFO pointers and bit/cycle counters cleared.
  - Reset mid-frame aborts the frame immediately; uart_tx returns high asynchronously and queued data is discarded.
- FIFO:
  - Push on start && ready. Pop only by the FSM.
  - Push while full (ready=0) is ignored: no state change, data dropped.
  - Simultaneous push and pop leaves fifo_count unchanged; the data is stored correctly.
  - Pointers wrap modulo FIFO_DEPTH.
  - ready and fifo_count are registered and reflect state after each edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, drive uart_tx=0, clear counter, go to START.
    - The first start-bit cycle is therefore the edge after the accepting push edge.
  - START: hold 0 for DELAY_FRAMES cycles total, then go to DATA with bit index 0.
  - DATA: drive data[idx] LSB first, DELAY_FRAMES cycles per bit.
    - After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
  - PARITY: drive the parity bit for DELAY_FRAMES cycles.
    - Even parity = XOR of data bits; odd parity = inverted XOR.
    - Computed from the latched word, not the live FIFO head.
  - STOP: drive 1 for STOP_BITS*DELAY_FRAMES cycles.
    - On the last cycle, if the FIFO is non-empty, pop and enter START directly (uart_tx=0 next cycle, no extra idle cycle).
    - Otherwise go to IDLE.
- Frame length in cycles = DELAY_FRAMES*(1+DATA_BITS+(PARITY!=0)+STOP_BITS), exactly.
- uart_tx is registered (glitch-free). Each bit level changes only on bit boundaries.
- A push into an empty FIFO during STOP's last cycle is popped on that same edge only if it is already visible. It is not visible, because the push is registered, so it starts one cycle later via IDLE. This one-cycle gap is required behaviour.
- The cycle counter width is $clog2(STOP_BITS*DELAY_FRAMES)+1. There is no overflow path.
- busy deasserts on the edge the FSM returns to IDLE with an empty FIFO.

Test Plan (DELAY_FRAMES=4 unless noted):
- Reset/idle: hold rst_n=0, then release -> uart_tx=1, ready=1, busy=0, fifo_count=0 for 20 cycles with start=0.
- 8N1 single byte: push 0xA5 -> uart_tx low starting the edge after the push. Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1 (start, LSB first), then 1. Frame = 40 cycles; busy falls at cycle 41.
- Parity/width:
  - DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x55 -> 7 data bits 1010101, parity 0, two stop bits, frame = 44 cycles.
  - Same setup with PARITY=1 -> parity bit 1.
- FIFO full/back-to-back:
  - FIFO_DEPTH=4: push 0x01..0x05 on consecutive cycles. The first pop frees a slot before the 5th push (fifo_count 1,1,2,3,4). A 6th push while fifo_count=4 and ready=0 is dropped.
  - 5 frames are sent with no idle gap between them; the byte order matches push order.
- Simultaneous push/pop: push exactly on the edge the FSM pops during STOP end with fifo_count=2 -> fifo_count stays 2, and the next frames carry the correct bytes.
- Reset mid-frame: assert rst_n during the DATA bit 3 of a queued 3-byte burst -> uart_tx=1 immediately, fifo_count=0. After release, no residual frame is sent.
